mem_stage_lsu: RTL

- Memory-stage load/store unit of the pipelined OTTER core.
- Consumes the E-to-M pipeline register outputs: ALUResultM, WriteDataM, MemWriteM, MemSizeM, MemSignM.
- Runs a req/ack transaction on the data-memory bus, generating byte enables and lane-replicated store data.
- Sign/zero-extends load data into ReadDataM for the M-to-W register; holds the pipeline via StallM while the bus is busy.

---
 rtl/mem_stage_lsu.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - OTTER memory-stage load/store unit (req/ack bus, optional LSU_TIMEOUT_EN abort)
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        MemValidM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [1:0]  MemSizeM,
    input  logic        MemSignM,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  MEM_BE,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        req_q, we_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic [1:0]  size_q, off_q;
    logic        sign_q;

    logic        access, misalign, issue, timeout_hit;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, shifted, load_ext;

    assign access = MemValidM & (MemReadM | MemWriteM);

    always_comb begin
        misalign = 1'b0;
        be_d     = 4'b1111;
        wdata_d  = WriteDataM;
        case (MemSizeM)
            2'b00: begin
                be_d    = 4'b0001 << ALUResultM[1:0];
                wdata_d = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                misalign = ALUResultM[0];
                be_d     = 4'b0011 << ALUResultM[1:0];
                wdata_d  = {2{WriteDataM[15:0]}};
            end
            default: misalign = |ALUResultM[1:0];
        endcase
    end

    assign issue     = (state_q == S_IDLE) & access & ~misalign;
    assign StallM    = issue | (state_q == S_REQ);
    assign MisalignM = (state_q == S_IDLE) & access & misalign;

    // Size/sign/offset are captured at issue so extraction never depends on the frozen E-to-M register.
    always_comb begin
        shifted  = MEM_RDATA >> {off_q, 3'b000};
        load_ext = shifted;
        case (size_q)
            2'b00:   load_ext = sign_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = sign_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             bus_err_q;

    assign timeout_hit = (state_q == S_REQ) & ~MEM_ACK & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign BusErrM     = bus_err_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout_hit;
            if (state_q == S_REQ && !MEM_ACK && !timeout_hit)
                cnt_q <= cnt_q + 1'b1;
            else
                cnt_q <= '0;
        end
    end
`else
    localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
    assign BusErrM     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue) state_d = S_REQ;
            S_REQ:   if (MEM_ACK || timeout_hit) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            off_q   <= '0;
            sign_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                req_q   <= 1'b1;
                we_q    <= MemWriteM;
                addr_q  <= {ALUResultM[31:2], 2'b00};
                be_q    <= be_d;
                wdata_q <= wdata_d;
                size_q  <= MemSizeM;
                off_q   <= ALUResultM[1:0];
                sign_q  <= MemSignM;
            end else if (state_q == S_REQ) begin
                if (MEM_ACK) begin
                    req_q <= 1'b0;
                    if (!we_q)
                        rdata_q <= load_ext;
                end else if (timeout_hit) begin
                    req_q   <= 1'b0;
                    rdata_q <= '0;
                end
            end
        end
    end

    assign MEM_REQ   = req_q;
    assign MEM_WE    = we_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_BE    = be_q;
    assign MEM_WDATA = wdata_q;
    assign ReadDataM = rdata_q;

endmodule
